// File: rtl/variable_length_encoder.sv
// Packs variable-length symbols MSB-first into a bitstream and presents it as
// fixed-width words through a show-ahead register; flush zero-pads the tail.
module variable_length_encoder #(
    parameter int WIDTH_IN     = 8,
    parameter int WIDTH_OUT    = 8,
    parameter int BUFFER_WIDTH = WIDTH_IN + WIDTH_OUT,
    parameter int SIZE_WIDTH   = 4,
    parameter int COUNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH_IN-1:0]   d,
    input  logic [SIZE_WIDTH-1:0] size,
    output logic                  full,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [WIDTH_OUT-1:0]  q,
    output logic                  empty,
    input  logic                  pop
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                   state, state_next;
    logic [BUFFER_WIDTH-1:0]  buffer, buffer_next, buffer_kept, sym_aligned;
    logic [COUNT_WIDTH-1:0]   count, count_next, count_kept, eff_size;
    logic [WIDTH_IN-1:0]      sym_mask;
    logic [WIDTH_OUT-1:0]     q_next;
    logic                     empty_next, flush_done_next;
    logic                     accepted, slot_free, load_q, pad_q;

    // Deliberately pessimistic: ignores any word leaving the buffer this cycle.
    assign full = (state == FLUSH) || (count > COUNT_WIDTH'(BUFFER_WIDTH - WIDTH_IN));

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        state_next      = state;
        buffer_kept     = buffer;
        count_kept      = count;
        q_next          = q;
        empty_next      = empty;
        flush_done_next = 1'b0;

        eff_size  = (size > SIZE_WIDTH'(WIDTH_IN)) ? COUNT_WIDTH'(WIDTH_IN) : COUNT_WIDTH'(size);
        sym_mask  = ~({WIDTH_IN{1'b1}} << eff_size);
        accepted  = push && !full;
        slot_free = empty || pop;
        load_q    = (count >= COUNT_WIDTH'(WIDTH_OUT)) && slot_free;
        pad_q     = (state == FLUSH) && (count != '0)
                    && (count < COUNT_WIDTH'(WIDTH_OUT)) && slot_free;

        // Bits below count are always zero, so the padded word is just the top slice.
        if (load_q) begin
            q_next      = buffer[BUFFER_WIDTH-1 -: WIDTH_OUT];
            empty_next  = 1'b0;
            buffer_kept = buffer << WIDTH_OUT;
            count_kept  = count - COUNT_WIDTH'(WIDTH_OUT);
        end else if (pad_q) begin
            q_next      = buffer[BUFFER_WIDTH-1 -: WIDTH_OUT];
            empty_next  = 1'b0;
            buffer_kept = '0;
            count_kept  = '0;
        end else if (pop) begin
            empty_next  = 1'b1;
        end

        // Left-align the symbol, then slide it just below the surviving bits.
        sym_aligned                 = '0;
        sym_aligned[WIDTH_IN-1:0]   = d & sym_mask;
        sym_aligned                 = (sym_aligned << (COUNT_WIDTH'(BUFFER_WIDTH) - eff_size))
                                      >> count_kept;

        buffer_next = buffer_kept | (accepted ? sym_aligned : '0);
        count_next  = count_kept + (accepted ? eff_size : '0);

        case (state)
            IDLE: begin
                if (flush) state_next = FLUSH;
            end
            FLUSH: begin
                if (count == '0) begin
                    state_next      = IDLE;
                    flush_done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the packing buffer is a plain register, so it is cleared on reset like the rest of the state.
        if (rst) begin
            state      <= IDLE;
            buffer     <= '0;
            count      <= '0;
            q          <= '0;
            empty      <= 1'b1;
            flush_done <= 1'b0;
        end else begin
            state      <= state_next;
            buffer     <= buffer_next;
            count      <= count_next;
            q          <= q_next;
            empty      <= empty_next;
            flush_done <= flush_done_next;
        end
    end

endmodule

// File: tb/tb_variable_length_encoder.sv
// Directed-vector bench for variable_length_encoder at default parameters.
module tb_variable_length_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [7:0] d;
    logic [3:0] size;
    logic       full;
    logic       flush;
    logic       flush_done;
    logic [7:0] q;
    logic       empty;
    logic       pop;

    int errors = 0;
    int checks = 0;

    variable_length_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .d          (d),
        .size       (size),
        .full       (full),
        .flush      (flush),
        .flush_done (flush_done),
        .q          (q),
        .empty      (empty),
        .pop        (pop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles with idle inputs, counting flush_done pulses and noting any valid word.
    task automatic watch(input int n, output int pulses, output logic saw_word, output logic [7:0] word);
        pulses   = 0;
        saw_word = 1'b0;
        word     = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (flush_done) pulses++;
            if (!empty && !saw_word) begin
                saw_word = 1'b1;
                word     = q;
            end
        end
    endtask

    int         pulses;
    logic       saw_word;
    logic [7:0] word;

    initial begin
        rst = 1'b1; push = 1'b0; d = '0; size = '0; flush = 1'b0; pop = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("reset_empty", 16'(empty), 16'd1);
        check("reset_full", 16'(full), 16'd0);
        check("reset_q", 16'(q), 16'h00);
        check("reset_flush_done", 16'(flush_done), 16'd0);

        // Packing: 101 followed by 11111 -> 1011_1111
        push = 1'b1; d = 8'h05; size = 4'd3; tick();
        d = 8'h1F; size = 4'd5; tick();
        push = 1'b0;
        check("pack_latency_empty", 16'(empty), 16'd1);
        tick();
        check("pack_empty", 16'(empty), 16'd0);
        check("pack_q", 16'(q), 16'hBF);
        pop = 1'b1; tick(); pop = 1'b0;
        check("pack_pop_empty", 16'(empty), 16'd1);

        // Backpressure
        push = 1'b1; size = 4'd8;
        d = 8'hA1; tick();
        d = 8'hB2; tick();
        d = 8'hC3; tick();
        push = 1'b0;
        check("bp_q_first", 16'(q), 16'hA1);
        check("bp_full", 16'(full), 16'd1);
        push = 1'b1; d = 8'hD4; tick(); push = 1'b0;
        check("bp_full_hold", 16'(full), 16'd1);
        pop = 1'b1;
        tick(); check("bp_q_second", 16'(q), 16'hB2);
        tick(); check("bp_q_third", 16'(q), 16'hC3);
        check("bp_full_released", 16'(full), 16'd0);
        tick(); pop = 1'b0;
        check("bp_drained_empty", 16'(empty), 16'd1);
        tick();
        check("bp_no_d4", 16'(empty), 16'd1);

        // Flush padding: 11 -> 1100_0000
        push = 1'b1; d = 8'h03; size = 4'd2; tick(); push = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_full_in_flush", 16'(full), 16'd1);
        tick();
        check("flush_pad_q", 16'(q), 16'hC0);
        check("flush_pad_empty", 16'(empty), 16'd0);
        check("flush_done_early", 16'(flush_done), 16'd0);
        tick();
        check("flush_done_pulse", 16'(flush_done), 16'd1);
        check("flush_full_after", 16'(full), 16'd0);
        tick();
        check("flush_done_single", 16'(flush_done), 16'd0);
        pop = 1'b1; tick(); pop = 1'b0;
        check("flush_pop_empty", 16'(empty), 16'd1);

        // Flush with a push on the same cycle: 111 -> 1110_0000
        push = 1'b1; d = 8'h07; size = 4'd3; flush = 1'b1; tick();
        push = 1'b0; flush = 1'b0;
        watch(6, pulses, saw_word, word);
        check("flush_push_pulses", 16'(pulses), 16'd1);
        check("flush_push_word_seen", 16'(saw_word), 16'd1);
        check("flush_push_q", 16'(word), 16'hE0);
        pop = 1'b1; tick(); pop = 1'b0;

        // Flush with nothing buffered
        flush = 1'b1; tick(); flush = 1'b0;
        watch(5, pulses, saw_word, word);
        check("flush_idle_pulses", 16'(pulses), 16'd1);
        check("flush_idle_no_word", 16'(saw_word), 16'd0);

        // Edge sizes: size=0 adds nothing, size=12 is clamped to 8
        push = 1'b1; d = 8'h00; size = 4'd0; tick();
        push = 1'b0;
        check("size0_full", 16'(full), 16'd0);
        tick();
        check("size0_empty", 16'(empty), 16'd1);
        push = 1'b1; d = 8'hFF; size = 4'd12; tick(); push = 1'b0;
        tick();
        check("size12_q", 16'(q), 16'hFF);
        check("size12_full", 16'(full), 16'd0);
        pop = 1'b1; tick();
        check("size12_pop_empty", 16'(empty), 16'd1);
        tick(); pop = 1'b0;
        check("pop_while_empty", 16'(empty), 16'd1);
        check("pop_while_empty_stale_q", 16'(q), 16'hFF);

        // Async reset mid-stream with q valid and 5 bits buffered
        push = 1'b1; d = 8'hAB; size = 4'd8; tick();
        d = 8'h1F; size = 4'd5; tick(); push = 1'b0;
        check("pre_reset_q", 16'(q), 16'hAB);
        #2 rst = 1'b1;
        #1;
        check("async_reset_empty", 16'(empty), 16'd1);
        check("async_reset_full", 16'(full), 16'd0);
        check("async_reset_q", 16'(q), 16'h00);
        #2 rst = 1'b0;
        push = 1'b1; d = 8'hAA; size = 4'd8; tick(); push = 1'b0;
        tick();
        check("post_reset_q", 16'(q), 16'hAA);
        check("post_reset_empty", 16'(empty), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/variable_length_encoder.md
Name: variable_length_encoder

Overview:
- Transmit-side counterpart of the argument decoding path.
- Accepts variable-length symbols (1..WIDTH_IN bits each) and packs them MSB-first into a contiguous bitstream.
- Emits fixed WIDTH_OUT-bit words through a show-ahead output register (q/empty/pop), ready to push into the asymmetric FIFO feeding the link.
- A flush request zero-pads the trailing partial word so the decoder receives whole words.

Parameters:
- WIDTH_IN, 8, maximum symbol length in bits; width of d.
- WIDTH_OUT, 8, output word width.
- BUFFER_WIDTH, WIDTH_IN + WIDTH_OUT, packing buffer capacity in bits.
- SIZE_WIDTH, 4, width of size; must hold WIDTH_IN.
- COUNT_WIDTH, 5, width of internal bit counter; must hold BUFFER_WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- push  input  1  symbol valid; accepted when full=0
- d  input  WIDTH_IN  symbol; bits d[size-1:0] used, d[size-1] sent first
- size  input  SIZE_WIDTH  symbol length in bits
- full  output  1  encoder cannot accept a push this cycle
- flush  input  1  request zero-padded drain of buffered bits
- flush_done  output  1  one-cycle pulse: flush complete
- q  output  WIDTH_OUT  current output word, oldest bit at q[WIDTH_OUT-1]
- empty  output  1  q holds no valid word
- pop  input  1  consume q; ignored when empty=1

Behaviour:
- Async reset (rst=1, immediate, mid-operation included):
  - buffer cleared, count=0, state=IDLE
  - q=0, empty=1, full=0, flush_done=0
  - all in-flight bits discarded
- State: count = number of valid bits in buffer, left-aligned (oldest at MSB).
- Accept:
  - push && !full appends size bits below the existing count bits.
  - Effective size = min(size, WIDTH_IN).
  - size=0 is accepted with no state change.
  - push while full=1 is dropped; no state change.
- full = (state==FLUSH) || (count > BUFFER_WIDTH - WIDTH_IN).
  - Combinational from registers only.
  - Conservative: does not account for a same-cycle extraction.
- Extract (load_q) condition: count >= WIDTH_OUT && (empty || pop).
  - On load_q: q <= top WIDTH_OUT bits, empty <= 0, buffer shifts left by WIDTH_OUT.
- Pop with no reload: empty <= 1; q holds its stale value.
- Same-cycle count update: count_next = count - (load_q ? WIDTH_OUT : 0) + (accepted ? eff_size : 0). Extraction uses pre-push contents.
- Latency: push at edge N → count updated at N → word loaded into q at edge N+1 (if slot free) → empty=0 after N+1.
- Back-to-back: one word per cycle sustained with pop held high while count >= WIDTH_OUT.
- FSM:
  - IDLE:
    - flush=1 → FLUSH. A push on the same cycle is accepted first if full=0 and is included in the flush.
  - FLUSH:
    - full=1; further pushes dropped.
    - Normal extraction continues.
    - When 0 < count < WIDTH_OUT and (empty || pop): q <= remaining bits left-aligned, low bits zero; count <= 0; empty <= 0.
    - When count==0: → IDLE; flush_done=1 for exactly one cycle (registered, asserted the cycle after FLUSH sees count==0).
    - flush asserted while in FLUSH is ignored.
- Flush with count=0: FLUSH for one cycle, then flush_done, no word emitted.
- Buffer never overflows: full guarantees count + WIDTH_IN <= BUFFER_WIDTH.
- Bits are never reordered or lost except by rst or a push dropped while full.

Test Plan:
- Packing (defaults): push d=0x05 size=3, next cycle push d=0x1F size=5, pop=0 → empty falls, q=0xBF; pop → empty=1.
- Backpressure: pushes of 0xA1, 0xB2, 0xC3 (size 8), pop=0 → q=0xA1, full=1 after third push; fourth push 0xD4 dropped. Pops return 0xA1, 0xB2, 0xC3 in order, then empty=1; 0xD4 never appears.
- Flush padding: push d=0x3 size=2, then flush → q=0xC0, flush_done single pulse, full=1 only during FLUSH, full=0 after.
- Flush with push on same cycle: push d=0x7 size=3 with flush=1 → q=0xE0, one flush_done. Flush with nothing buffered → flush_done, empty stays 1.
- Edge sizes: size=0 push → no change. size=12 with d=0xFF → treated as 8, next word 0xFF. Pop while empty → no effect.
- Async reset: rst asserted between clock edges mid-stream (count=5, q valid) → empty=1, full=0, q=0 immediately. First post-reset push of 0xAA size 8 → q=0xAA.
